// File: rtl/cpu_bus_arbiter.sv
// cpu_bus_arbiter
//   Round-robin arbiter that lets two masters (CPU = master 0, debug/DMA =
//   master 1) share one peripheral bus, one single read or write at a time.
//   Each transaction walks IDLE -> ISSUE -> WAIT -> DONE.
//
// Ports
//   clk_i, reset_i              clock, synchronous active-high reset
//   mN_req_i                    request, held until mN_done_o
//   mN_we_i/addr_i/wdata_i      transaction attributes, latched at grant
//   mN_gnt_o                    master N owns the bus (ISSUE..DONE)
//   mN_done_o                   one-cycle completion pulse
//   mN_rdata_o                  read data, updated on completion, held after
//   bus_address_o/data_o/we_o   shared bus drive
//   bus_data_i                  shared bus read data
//   bus_busy_i                  downstream CDC busy, stalls the WAIT state
module cpu_bus_arbiter #(
  parameter int AddrWidth   = 16,
  parameter int DataWidth   = 32,
  parameter int ReadLatency = 2
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 m0_req_i,
  input  logic                 m0_we_i,
  input  logic [AddrWidth-1:0] m0_addr_i,
  input  logic [DataWidth-1:0] m0_wdata_i,
  output logic                 m0_gnt_o,
  output logic                 m0_done_o,
  output logic [DataWidth-1:0] m0_rdata_o,
  input  logic                 m1_req_i,
  input  logic                 m1_we_i,
  input  logic [AddrWidth-1:0] m1_addr_i,
  input  logic [DataWidth-1:0] m1_wdata_i,
  output logic                 m1_gnt_o,
  output logic                 m1_done_o,
  output logic [DataWidth-1:0] m1_rdata_o,
  output logic [AddrWidth-1:0] bus_address_o,
  output logic [DataWidth-1:0] bus_data_o,
  output logic                 bus_we_o,
  input  logic [DataWidth-1:0] bus_data_i,
  input  logic                 bus_busy_i
);

  localparam int CntWidth = $clog2(ReadLatency + 1);
  localparam logic [CntWidth-1:0] LastCnt = CntWidth'(ReadLatency - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic                   id_q, id_d;       // granted master
  logic                   we_q, we_d;
  logic [AddrWidth-1:0]   addr_q, addr_d;
  logic [DataWidth-1:0]   wdata_q, wdata_d;
  logic [CntWidth-1:0]    cnt_q, cnt_d;
  logic                   last_q, last_d;   // master that completed most recently
  logic                   capture;
  logic [1:0]             req;
  logic [1:0]             sel;
  logic [1:0]             gnt;
  logic [1:0]             done;
  logic [DataWidth-1:0]   rdata_q [2];
  logic [DataWidth-1:0]   rdata_d [2];

  assign req = {m1_req_i, m0_req_i};
  assign sel = {id_q, ~id_q};

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    capture = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          // On a tie the master that did not complete last wins.
          id_d    = (req == 2'b11) ? ~last_q : req[1];
          we_d    = id_d ? m1_we_i    : m0_we_i;
          addr_d  = id_d ? m1_addr_i  : m0_addr_i;
          wdata_d = id_d ? m1_wdata_i : m0_wdata_i;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (!bus_busy_i) begin
          if (we_q) begin
            state_d = S_DONE;
          end else if (cnt_q == LastCnt) begin
            // Counter stops here rather than advancing past the last slot.
            capture = 1'b1;
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + CntWidth'(1);
          end
        end
      end
      S_DONE: begin
        last_d  = id_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      id_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b1;   // master 0 wins the first tie
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  // Per-master grant, done and read-data holding register.
  for (genvar gi = 0; gi < 2; gi++) begin : g_master
    assign gnt[gi]  = sel[gi] && (state_q != S_IDLE);
    assign done[gi] = sel[gi] && (state_q == S_DONE);

    always_comb begin
      rdata_d[gi] = rdata_q[gi];
      if (capture && sel[gi]) begin
        rdata_d[gi] = bus_data_i;
      end
    end

    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        rdata_q[gi] <= '0;
      end else begin
        rdata_q[gi] <= rdata_d[gi];
      end
    end
  end

  assign m0_gnt_o   = gnt[0];
  assign m1_gnt_o   = gnt[1];
  assign m0_done_o  = done[0];
  assign m1_done_o  = done[1];
  assign m0_rdata_o = rdata_q[0];
  assign m1_rdata_o = rdata_q[1];

  // Address and write data are only on the bus while the access is in flight;
  // the write strobe is limited to the single ISSUE cycle.
  always_comb begin
    bus_address_o = '0;
    bus_data_o    = '0;
    bus_we_o      = 1'b0;
    if (state_q == S_ISSUE || state_q == S_WAIT) begin
      bus_address_o = addr_q;
      bus_data_o    = wdata_q;
    end
    if (state_q == S_ISSUE) begin
      bus_we_o = we_q;
    end
  end

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// tb_cpu_bus_arbiter
//   Drives directed and randomized transactions into cpu_bus_arbiter and
//   compares every output, every cycle, against a transaction-level model:
//   each transaction has a start edge T, and all expected outputs are derived
//   from T, the stall count and the access type by plain arithmetic.
//   Edge numbering: edge e is the e-th rising clock edge; "observation e" is
//   the DUT output value just before edge e.
module tb_cpu_bus_arbiter;

  localparam int AW   = 16;
  localparam int DW   = 32;
  localparam int RL   = 2;
  localparam int MAXC = 4096;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic          m0_req_i, m0_we_i, m0_gnt_o, m0_done_o;
  logic [AW-1:0] m0_addr_i;
  logic [DW-1:0] m0_wdata_i, m0_rdata_o;
  logic          m1_req_i, m1_we_i, m1_gnt_o, m1_done_o;
  logic [AW-1:0] m1_addr_i;
  logic [DW-1:0] m1_wdata_i, m1_rdata_o;
  logic [AW-1:0] bus_address_o;
  logic [DW-1:0] bus_data_o, bus_data_i;
  logic          bus_we_o, bus_busy_i;

  always #5 clk_i = ~clk_i;

  cpu_bus_arbiter #(.AddrWidth(AW), .DataWidth(DW), .ReadLatency(RL)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_addr_i(m0_addr_i),
    .m0_wdata_i(m0_wdata_i), .m0_gnt_o(m0_gnt_o), .m0_done_o(m0_done_o),
    .m0_rdata_o(m0_rdata_o),
    .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_addr_i(m1_addr_i),
    .m1_wdata_i(m1_wdata_i), .m1_gnt_o(m1_gnt_o), .m1_done_o(m1_done_o),
    .m1_rdata_o(m1_rdata_o),
    .bus_address_o(bus_address_o), .bus_data_o(bus_data_o),
    .bus_we_o(bus_we_o), .bus_data_i(bus_data_i), .bus_busy_i(bus_busy_i)
  );

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  logic [DW-1:0] bd [MAXC];      // bus_data_i value sampled at each edge
  bit            rst_at [MAXC];  // reset sampled at each edge

  // Pending request per master
  bit            pend [2];
  bit            p_we [2];
  logic [AW-1:0] p_addr [2];
  logic [DW-1:0] p_wdata [2];
  int            req_start [2];

  // Current transaction
  bit            act      = 1'b0;
  int            t_s      = 0;
  int            t_d      = 0;
  int            t_k      = 0;
  int            w        = 0;
  bit            t_drop   = 1'b0;
  bit            cw       = 1'b0;
  logic [AW-1:0] ca       = '0;
  logic [DW-1:0] cd       = '0;
  int            rst_edge = -1;
  int            abort_e  = 1 << 30;
  bit            fix_en   = 1'b0;
  logic [DW-1:0] fix_val  = '0;

  bit            last   = 1'b1;
  logic [DW-1:0] rd_model [2];
  int            prev_d = 2;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s @obs %0d: got %0h expected %0h", tag, cyc + 1, got, exp);
    end
  endtask

  task automatic drive(input int e);
    bit r [2];
    rst_at[e] = (e <= 2) || (e == rst_edge);
    reset_i   = rst_at[e];
    for (int m = 0; m < 2; m++) begin
      r[m] = pend[m] && (e >= req_start[m]) &&
             !(act && w == m && ((t_drop && e > t_s) || e > abort_e));
    end
    m0_req_i = r[0]; m0_we_i = p_we[0]; m0_addr_i = p_addr[0]; m0_wdata_i = p_wdata[0];
    m1_req_i = r[1]; m1_we_i = p_we[1]; m1_addr_i = p_addr[1]; m1_wdata_i = p_wdata[1];
    if (act && e >= t_s + 2 && e < t_d && e <= abort_e)
      bus_busy_i = (e < t_s + 2 + t_k);
    else
      bus_busy_i = 1'($urandom_range(0, 1));
    bd[e]      = (fix_en && act && e > t_s && e <= t_d) ? fix_val : DW'($urandom);
    bus_data_i = bd[e];
  endtask

  task automatic observe(input int e);
    bit live;
    if (rst_at[e-1]) begin
      rd_model[0] = '0;
      rd_model[1] = '0;
    end
    live = act && e > t_s && e <= t_d && e <= abort_e;
    if (live && e == t_d && !cw) rd_model[w] = bd[t_d-1];
    check_eq("m0_gnt",  m0_gnt_o,  live && w == 0);
    check_eq("m1_gnt",  m1_gnt_o,  live && w == 1);
    check_eq("m0_done", m0_done_o, live && e == t_d && w == 0);
    check_eq("m1_done", m1_done_o, live && e == t_d && w == 1);
    check_eq("bus_we",  bus_we_o,  live && e == t_s + 1 && cw);
    check_eq("bus_addr", bus_address_o, (live && e < t_d) ? ca : '0);
    if (live && e == t_s + 1) check_eq("bus_wdata", bus_data_o, cd);
    else if (!live || e == t_d) check_eq("bus_wdata_idle", bus_data_o, '0);
    check_eq("m0_rdata", m0_rdata_o, rd_model[0]);
    check_eq("m1_rdata", m1_rdata_o, rd_model[1]);
  endtask

  task automatic tick();
    int e;
    @(posedge clk_i);
    cyc++;
    #1;
    e = cyc + 1;
    if (e >= MAXC) begin
      $display("FAIL cycle_budget: got %0d cycles expected < %0d", e, MAXC);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
      $fatal(1, "cycle budget exhausted");
    end
    drive(e);
    @(negedge clk_i);
    observe(e);
  endtask

  task automatic new_req(input int m, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    pend[m]      = 1'b1;
    p_we[m]      = we;
    p_addr[m]    = a;
    p_wdata[m]   = d;
    req_start[m] = -1;
  endtask

  // Runs one transaction: the model picks the winner, predicts the start edge
  // and completion edge, then the bench clocks through it checking outputs.
  task automatic run_txn(input int k, input bit drop, input int gap, input int abort_off,
                         input bit fen, input logic [DW-1:0] fval);
    bit carry;
    int end_e;
    carry = 1'b0;
    for (int m = 0; m < 2; m++) if (pend[m] && req_start[m] >= 0) carry = 1'b1;
    t_s = prev_d + 1 + (carry ? 0 : gap);
    for (int m = 0; m < 2; m++) if (pend[m] && req_start[m] < 0) req_start[m] = t_s;
    if (pend[0] && pend[1]) w = last ? 0 : 1;
    else                    w = pend[1] ? 1 : 0;
    cw = p_we[w]; ca = p_addr[w]; cd = p_wdata[w];
    t_k = k; t_drop = drop; fix_en = fen; fix_val = fval;
    t_d = t_s + 2 + k + (cw ? 1 : RL);
    abort_e  = (abort_off > 0) ? t_s + abort_off : (1 << 30);
    rst_edge = (abort_off > 0) ? t_s + abort_off : -1;
    act = 1'b1;
    end_e = (abort_off > 0) ? abort_e + 1 : t_d;
    while (cyc + 2 <= end_e) tick();
    pend[w]      = 1'b0;
    req_start[w] = -1;
    if (abort_off > 0) begin
      last   = 1'b1;
      prev_d = abort_e;
    end else begin
      last   = (w == 1);
      prev_d = t_d;
    end
  endtask

  initial begin
    reset_i = 1'b1;
    m0_req_i = 1'b0; m0_we_i = 1'b0; m0_addr_i = '0; m0_wdata_i = '0;
    m1_req_i = 1'b0; m1_we_i = 1'b0; m1_addr_i = '0; m1_wdata_i = '0;
    bus_data_i = '0; bus_busy_i = 1'b0;
    bd[1] = '0; rst_at[1] = 1'b1;
    rd_model[0] = '0; rd_model[1] = '0;
    for (int m = 0; m < 2; m++) begin
      pend[m] = 1'b0; p_we[m] = 1'b0; p_addr[m] = '0; p_wdata[m] = '0; req_start[m] = -1;
    end

    // m0 read at 'h9000 returning 'hDEADBEEF
    new_req(0, 1'b0, 16'h9000, $urandom);
    run_txn(0, 1'b0, 1, 0, 1'b1, 32'hDEADBEEF);
    // m1 write 'h12345678 to 'h9004
    new_req(1, 1'b1, 16'h9004, 32'h12345678);
    run_txn(0, 1'b0, 1, 0, 1'b0, '0);
    // Both masters requesting: grants must alternate m0,m1,m0,m1
    for (int j = 0; j < 4; j++) begin
      for (int m = 0; m < 2; m++)
        if (!pend[m]) new_req(m, 1'(j & 1), AW'(16'h100 + 4 * j + m), $urandom);
      run_txn(0, 1'b0, 0, 0, 1'b0, '0);
    end
    while (pend[0] || pend[1]) run_txn(0, 1'b0, 0, 0, 1'b0, '0);
    // Read stalled by 7 busy cycles
    new_req(0, 1'b0, 16'h9010, $urandom);
    run_txn(7, 1'b0, 1, 0, 1'b0, '0);
    // m0 drops req right after the grant edge
    new_req(0, 1'b0, 16'h9020, $urandom);
    run_txn(1, 1'b1, 0, 0, 1'b0, '0);

    // Randomized traffic
    for (int i = 0; i < 100; i++) begin
      for (int m = 0; m < 2; m++)
        if (!pend[m] && $urandom_range(0, 1) == 1)
          new_req(m, 1'($urandom_range(0, 1)), AW'($urandom), $urandom);
      if (!pend[0] && !pend[1])
        new_req($urandom_range(0, 1), 1'($urandom_range(0, 1)), AW'($urandom), $urandom);
      run_txn($urandom_range(0, 4), 1'($urandom_range(0, 1)), $urandom_range(0, 2), 0, 1'b0, '0);
    end
    while (pend[0] || pend[1]) run_txn($urandom_range(0, 3), 1'b0, 0, 0, 1'b0, '0);

    // Reset during the WAIT state of an m1 read, then a normal m0 read
    new_req(1, 1'b0, 16'hA000, $urandom);
    run_txn(10, 1'b0, 2, 4, 1'b0, '0);
    new_req(0, 1'b0, 16'h9008, $urandom);
    run_txn(0, 1'b0, 3, 0, 1'b0, '0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
